// File: rtl/cpu_flags_pkg.sv
// cpu_flags_pkg: flag bit positions and register width shared by the flags unit
package cpu_flags_pkg;
  localparam int FLAG_N  = 0;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_C  = 2;
  localparam int FLAG_V  = 3;
  localparam int FLAGS_W = 4;
endpackage

// File: rtl/cpu_flags_unit_flag_reg4.sv
// flag_reg4: 4-bit register with synchronous active-high reset and load enable
module flag_reg4
  import cpu_flags_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [FLAGS_W-1:0] d,
  output logic [FLAGS_W-1:0] q
);
  logic [FLAGS_W-1:0] q_d, q_q;
  // hold unless enabled
  always_comb q_d = en ? d : q_q;
  // reset overrides the enable
  always_ff @(posedge clk)
    q_q <= reset ? '0 : q_d;
  assign q = q_q;
endmodule

// File: rtl/cpu_flags_unit.sv
// cpu_flags_unit: NZCV status register fed by ALU results or bus loads, with staged copy for branch logic
module cpu_flags_unit
  import cpu_flags_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         boutn,
  input  logic         bloadn,
  input  logic         calcn,
  input  logic [7:0]   bus_in,
  output logic [7:0]   bus_out,
  output logic         bus_oe,
  input  logic         vin,
  input  logic         vin_valid,
  input  logic         cin,
  input  logic         cin_valid,
  output logic [3:0]   fout
);
  logic               en;
  logic [FLAGS_W-1:0] prim_d, prim;
  // calc strobe wins over bus load; unsupplied C/V keep their old value
  always_comb begin
    en             = ~(bloadn & calcn);
    prim_d         = bus_in[3:0];
    prim_d[FLAG_V] = calcn ? bus_in[FLAG_V] : (vin_valid ? vin : prim[FLAG_V]);
    prim_d[FLAG_C] = calcn ? bus_in[FLAG_C] : (cin_valid ? cin : prim[FLAG_C]);
    prim_d[FLAG_Z] = calcn ? bus_in[FLAG_Z] : (bus_in == 8'h00);
    prim_d[FLAG_N] = calcn ? bus_in[FLAG_N] : bus_in[7];
  end
  flag_reg4 u_prim  (.clk(clk), .reset(reset), .en(en),   .d(prim_d), .q(prim));
  flag_reg4 u_stage (.clk(clk), .reset(reset), .en(1'b1), .d(prim),   .q(fout));
  assign bus_out = {4'b0000, prim};
  assign bus_oe  = ~boutn;
endmodule

// File: tb/tb_cpu_flags_unit.sv
// tb_cpu_flags_unit: directed and randomized checks of cpu_flags_unit against a flag-level model
module tb_cpu_flags_unit;
  logic clk = 0, reset = 1, boutn = 1, bloadn = 1, calcn = 1;
  logic [7:0] bus_in = 0, bus_out;
  logic bus_oe, vin = 0, vin_valid = 0, cin = 0, cin_valid = 0;
  logic [3:0] fout;
  int checks = 0, errors = 0;
  bit run = 0;
  logic n_f, z_f, c_f, v_f, n_s, z_s, c_s, v_s;

  cpu_flags_unit dut (.clk(clk), .reset(reset), .boutn(boutn), .bloadn(bloadn), .calcn(calcn),
    .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe), .vin(vin), .vin_valid(vin_valid),
    .cin(cin), .cin_valid(cin_valid), .fout(fout));

  always #5 clk = ~clk;

  function automatic logic [3:0] m_prim();
    return {v_f, c_f, z_f, n_f};
  endfunction
  function automatic logic [3:0] m_fout();
    return {v_s, c_s, z_s, n_s};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      {n_f, z_f, c_f, v_f, n_s, z_s, c_s, v_s} = '0;
    end else begin
      {n_s, z_s, c_s, v_s} = {n_f, z_f, c_f, v_f};
      if (!calcn) begin
        n_f = bus_in[7];
        z_f = (bus_in == 0);
        if (cin_valid) c_f = cin;
        if (vin_valid) v_f = vin;
      end else if (!bloadn) begin
        n_f = bus_in[0]; z_f = bus_in[1]; c_f = bus_in[2]; v_f = bus_in[3];
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (run) begin
    chk("bus_out", bus_out, {4'b0, m_prim()});
    chk("bus_oe", {7'b0, bus_oe}, {7'b0, ~boutn});
    chk("fout", {4'b0, fout}, {4'b0, m_fout()});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    cyc();
    chk("reset_prim", bus_out, 8'h00);
    chk("reset_fout", {4'b0, fout}, 8'h00);
    chk("reset_oe", {7'b0, bus_oe}, 8'h00);
    reset = 0;
    run = 1;
    calcn = 0; bus_in = 8'h00; vin = 0; cin = 1; vin_valid = 1; cin_valid = 1;
    cyc();
    chk("calc_zero", bus_out, 8'h06);
    chk("model_calc_zero", {4'b0, m_prim()}, 8'h06);
    calcn = 1;
    cyc();
    chk("calc_zero_fout", {4'b0, fout}, 8'h06);
    bloadn = 0; bus_in = 8'h0C;
    cyc();
    bloadn = 1; calcn = 0; bus_in = 8'h80; vin_valid = 0; cin_valid = 0; vin = 0; cin = 0;
    cyc();
    chk("calc_neg_keep_cv", bus_out, 8'h0D);
    chk("model_calc_neg", {4'b0, m_prim()}, 8'h0D);
    calcn = 1; bloadn = 0; bus_in = 8'hA9;
    cyc();
    bloadn = 1;
    chk("load_a9", bus_out, 8'h09);
    boutn = 0;
    #1;
    chk("drive_oe", {7'b0, bus_oe}, 8'h01);
    chk("drive_bus", bus_out, 8'h09);
    boutn = 1;
    bloadn = 0; calcn = 0; bus_in = 8'h05; vin = 1; cin = 0; vin_valid = 1; cin_valid = 1;
    cyc();
    chk("both_strobes", bus_out, 8'h08);
    chk("model_both", {4'b0, m_prim()}, 8'h08);
    bloadn = 1; calcn = 1;
    for (int i = 0; i < 3; i++) begin
      bus_in = 8'($urandom); vin = 1'($urandom); cin = 1'($urandom);
      cyc();
    end
    chk("hold_prim", bus_out, 8'h08);
    chk("hold_fout", {4'b0, fout}, 8'h08);
    calcn = 0; bus_in = 8'hFF; reset = 1;
    cyc();
    chk("midreset_prim", bus_out, 8'h00);
    chk("midreset_fout", {4'b0, fout}, 8'h00);
    reset = 0; calcn = 1;
    cyc();
    chk("midreset_fout_next", {4'b0, fout}, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      boutn = 1'($urandom); bloadn = 1'($urandom); calcn = 1'($urandom);
      bus_in = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      vin = 1'($urandom); cin = 1'($urandom);
      vin_valid = 1'($urandom); cin_valid = 1'($urandom);
      cyc();
    end
    @(negedge clk);
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
